sq_wave_sequencer: RTL
======================

# sq_wave_sequencer

Plays a programmed sequence of notes on the square-wave generator. Each note is a half-period value plus a duration counted in DAC samples. The block sits between the top-level control logic and the square-wave generator: it drives the generator's period setting and counts the generator's `next_sample` pulses to decide when to advance to the next note. A small internal note table is written through a program port while the block is idle.

## Interface
- `DEPTH`, 8: number of note-table entries; must be a power of two, at least 2.
- `PERIOD_W`, 16: width of a note period, in clk cycles per half-period.
- `DUR_W`, 16: width of a note duration, in samples.
- `clk`  in  1  system clock; all state is updated on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `prog_we`  in  1  note-table write strobe; accepted only in IDLE or DONE.
- `prog_addr`  in  log2(DEPTH)  note-table write index.
- `prog_period`  in  PERIOD_W  note period to write; 0 means rest.
- `prog_dur`  in  DUR_W  note duration to write; 0 means end-of-sequence marker.
- `start`  in  1  level-sampled; begins playback from entry 0 when in IDLE or DONE.
- `stop`  in  1  aborts playback; returns to IDLE.
- `loop`  in  1  wrap to entry 0 instead of finishing (present only with `SEQ_LOOP_EN`).
- `next_sample`  in  1  one-cycle pulse from the DAC pacing logic; one pulse = one sample consumed.
- `period_out`  out  PERIOD_W  period driven to the square-wave generator.
- `mute`  out  1  high when no note is sounding (IDLE, DONE, or a rest entry).
- `note_idx`  out  log2(DEPTH)  index of the note currently loaded.
- `busy`  out  1  high in LOAD and PLAY.
- `done`  out  1  one-cycle pulse when the sequence ends.

## Operation
- States are IDLE, LOAD, PLAY and DONE.
- **IDLE:**
  - On `start` (and no `stop`): `idx`←0, go to LOAD.
  - `prog_we` writes entry `prog_addr`.
- **LOAD:**
  - Registered table read of entry `idx`.
  - If the entry's `dur`==0: go to DONE and pulse `done`. `period_out` and `note_idx` are not updated.
  - Otherwise: `period_out`←entry period, `mute`←(period==0), `cnt`←dur, `note_idx`←idx, go to PLAY.
- **PLAY:**
  - Each `next_sample` decrements `cnt`.
  - On `next_sample` with `cnt`==1, advance the index:
    - If idx==DEPTH-1: with `loop` set, idx←0 and go to LOAD; otherwise go to DONE and pulse `done`.
    - Else idx←idx+1 and go to LOAD.
- **DONE:**
  - `mute`=1; `period_out` holds its last value.
  - `start` restarts playback as from IDLE.
  - `prog_we` is accepted.
- **Priority:** `stop` > `start`. `stop` in any state goes to IDLE with `mute`=1 and no `done` pulse.
- **Ignored inputs:**
  - `start` while `busy`.
  - `prog_we` while `busy` (table contents unchanged).
- `next_sample` during LOAD is not counted; the generator plays that sample with the previous `period_out`.
- **Counter width:** `cnt` is DUR_W bits and never underflows; the zero-duration case is consumed in LOAD.
- **Table:** uninitialized after reset; software must program it before `start`.

## Timing
- **Reset values:**
  - State IDLE.
  - `period_out`=0, `mute`=1, `note_idx`=0, `busy`=0, `done`=0, `cnt`=0.
  - The note table is not reset.
- **Start latency:** with `start` sampled at edge N, LOAD is held during cycle N→N+1 and `period_out`/`mute` are valid after edge N+2.
- **Note switch:** with the last `next_sample` of a note sampled at edge M, the new `period_out` is valid after edge M+2.
- **Duration:** a note with `dur`=D consumes exactly D `next_sample` pulses counted in PLAY.
- **`done`:** high for exactly one cycle, in the cycle after the transition edge into DONE.
- **Reset mid-operation:** `rst_n` low forces the reset values immediately, independent of `clk`. Release is synchronous to the next edge.

## Configuration
- **`SEQ_LOOP_EN` defined:** the `loop` port exists, and wrap-around from DEPTH-1 to 0 is taken when `loop`=1.
- **`SEQ_LOOP_EN` undefined:** there is no `loop` port, and reaching DEPTH-1 (or a `dur`=0 entry) always ends in DONE.
- With or without the macro, a `dur`=0 entry terminates the sequence; looping never skips a terminator.

## Test plan
- Program {(100,3),(200,2),(0,0)}, pulse `start`, and issue `next_sample` every 4 cycles:
  - `period_out` is 100 for 3 counted samples, then 200 for 2.
  - `done` pulses once, `mute`=1, `note_idx`=1.
- Program entry 0 as (0,5) (a rest), then (50,1):
  - `mute`=1 during the first 5 samples.
  - Then `period_out`=50 and `mute`=0.
- Assert `stop` in PLAY at note 1, together with `start`:
  - Next state is IDLE, `mute`=1, no `done` pulse.
  - A following `start` replays from `note_idx`=0.
- Attempt `prog_we` to entry 0 with (999,9) while `busy`:
  - The entry is unchanged.
  - A replay after DONE still plays the original value.
- Fill all DEPTH=8 entries with (i+1,1):
  - With `SEQ_LOOP_EN` and `loop`=1, `note_idx` wraps 7→0 with no `done`.
  - Without the macro, `done` follows entry 7.
- Pull `rst_n` low mid-note, without a `clk` edge:
  - All outputs take their reset values at once.
  - After release the block stays in IDLE until `start`.

Source files
------------

// File: rtl/sq_wave_sequencer_if.sv
// Program/control/generator bundle for sq_wave_sequencer.
// The loop input exists only when SEQ_LOOP_EN is defined.
interface sq_wave_sequencer_if #(
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 16,
  parameter int DUR_W    = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                prog_we;
  logic [AW-1:0]       prog_addr;
  logic [PERIOD_W-1:0] prog_period;
  logic [DUR_W-1:0]    prog_dur;
  logic                start;
  logic                stop;
`ifdef SEQ_LOOP_EN
  logic                loop;
`endif
  logic                next_sample;
  logic [PERIOD_W-1:0] period_out;
  logic                mute;
  logic [AW-1:0]       note_idx;
  logic                busy;
  logic                done;

  modport master (
    output prog_we, prog_addr, prog_period, prog_dur, start, stop,
`ifdef SEQ_LOOP_EN
    output loop,
`endif
    output next_sample,
    input  period_out, mute, note_idx, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_period, prog_dur, start, stop,
`ifdef SEQ_LOOP_EN
    input  loop,
`endif
    input  next_sample,
    output period_out, mute, note_idx, busy, done
  );
endinterface

// File: rtl/sq_wave_sequencer.sv
// Note-table sequencer driving a square-wave generator's period, paced by next_sample.
// Optional wrap-around playback is enabled by defining SEQ_LOOP_EN.
module sq_wave_sequencer #(
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 16,
  parameter int DUR_W    = 16
) (
  input logic                clk,
  input logic                rst_n,
  sq_wave_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                mute_q, mute_d;
  logic [AW-1:0]       note_q, note_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ld_ph_q, ld_ph_d;
  logic                wrap;

  logic [PERIOD_W-1:0] tbl_period [DEPTH];
  logic [DUR_W-1:0]    tbl_dur    [DEPTH];
  logic [PERIOD_W-1:0] rd_period_q;
  logic [DUR_W-1:0]    rd_dur_q;
  logic                wr_en;

`ifdef SEQ_LOOP_EN
  assign wrap = bus.loop;
`else
  assign wrap = 1'b0;
`endif

  assign wr_en = bus.prog_we && (state_q == IDLE || state_q == DONE);

  // Table is deliberately unreset; the read port is registered every cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_period[bus.prog_addr] <= bus.prog_period;
      tbl_dur[bus.prog_addr]    <= bus.prog_dur;
    end
    rd_period_q <= tbl_period[idx_q];
    rd_dur_q    <= tbl_dur[idx_q];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    mute_d   = mute_q;
    note_d   = note_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ld_ph_d  = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      mute_d  = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            idx_d   = '0;
            state_d = LOAD;
            busy_d  = 1'b1;
          end
        end
        LOAD: begin
          // First LOAD cycle lets the read register catch up with the new idx.
          if (!ld_ph_q) begin
            ld_ph_d = 1'b1;
          end else if (rd_dur_q == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            mute_d  = 1'b1;
          end else begin
            period_d = rd_period_q;
            mute_d   = (rd_period_q == '0);
            cnt_d    = rd_dur_q;
            note_d   = idx_q;
            state_d  = PLAY;
          end
        end
        PLAY: begin
          if (bus.next_sample) begin
            cnt_d = cnt_q - DUR_W'(1);
            if (cnt_q == DUR_W'(1)) begin
              if (idx_q == LAST) begin
                if (wrap) begin
                  idx_d   = '0;
                  state_d = LOAD;
                end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  mute_d  = 1'b1;
                end
              end else begin
                idx_d   = idx_q + AW'(1);
                state_d = LOAD;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      mute_q   <= 1'b1;
      note_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ld_ph_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mute_q   <= mute_d;
      note_q   <= note_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ld_ph_q  <= ld_ph_d;
    end
  end

  assign bus.period_out = period_q;
  assign bus.mute       = mute_q;
  assign bus.note_idx   = note_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule
